// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the mem_arbiter front end.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    WAIT_WR
  } mem_arb_state_e;

  function automatic int unsigned port_idx_width(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Client request/response bus plus the mem_ctrl request port, as seen by mem_arbiter.
// slave = arbiter side, master = the clients and mem_ctrl driving it.
interface mem_arbiter_if #(
  parameter int unsigned num_ports  = 4,
  parameter int unsigned addr_width = 32,
  parameter int unsigned line_width = 64
);

  logic [num_ports-1:0]                 req_valid_i;
  logic [num_ports-1:0]                 req_write_i;
  logic [num_ports-1:0][addr_width-1:0] req_addr_i;
  logic [num_ports-1:0][line_width-1:0] req_wdata_i;
  logic [num_ports-1:0]                 req_ready_o;
  logic [num_ports-1:0]                 rsp_valid_o;
  logic                                 rsp_write_o;
  logic [line_width-1:0]                rsp_data_o;

  logic                                 mem_data_ready_i;
  logic [addr_width-1:0]                mem_addr_o;
  logic                                 mem_r_valid_o;
  logic                                 mem_w_valid_o;
  logic [line_width-1:0]                mem_write_o;
  logic                                 mem_r_valid_i;
  logic [line_width-1:0]                mem_read_i;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_write_o, rsp_data_o,
    input  mem_data_ready_i, mem_r_valid_i, mem_read_i,
    output mem_addr_o, mem_r_valid_o, mem_w_valid_o, mem_write_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_write_o, rsp_data_o,
    output mem_data_ready_i, mem_r_valid_i, mem_read_i,
    input  mem_addr_o, mem_r_valid_o, mem_w_valid_o, mem_write_o
  );

endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches from ptr_i+1, wrapping modulo num_ports.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int unsigned num_ports = 4,
  localparam int unsigned IdxW      = port_idx_width(num_ports)
) (
  input  logic [num_ports-1:0] req_i,
  input  logic [IdxW-1:0]      ptr_i,
  output logic [num_ports-1:0] gnt_o,
  output logic [IdxW-1:0]      idx_o
);

  always_comb begin
    logic        found;
    int unsigned cand;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 1; i <= num_ports; i++) begin
      cand = (32'(ptr_i) + i) % num_ports;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin multi-client front end for mem_ctrl, one transaction outstanding.
// Define MEM_ARB_PORT0_PRIO_EN to give port 0 absolute priority over the others.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned num_ports  = 4,
  parameter int unsigned addr_width = 32,
  parameter int unsigned line_width = 64
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned     IdxW     = port_idx_width(num_ports);
  localparam logic [IdxW-1:0] LastPort = IdxW'(num_ports - 1);
`ifdef MEM_ARB_PORT0_PRIO_EN
  localparam bit Port0Prio = 1'b1;
`else
  localparam bit Port0Prio = 1'b0;
`endif

  mem_arb_state_e        state_q, state_d;
  logic [IdxW-1:0]       last_grant_q, last_grant_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  write_q, write_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [line_width-1:0] wdata_q, wdata_d;
  logic [line_width-1:0] rsp_data_q, rsp_data_d;

  logic [num_ports-1:0]  arb_req, arb_gnt, win_gnt;
  logic [IdxW-1:0]       arb_idx, win_idx;

  // In priority mode port 0 is removed from the rotation and overrides it.
  assign arb_req = Port0Prio ? {bus.req_valid_i[num_ports-1:1], 1'b0} : bus.req_valid_i;

  rr_arbiter #(.num_ports(num_ports)) u_rr (
    .req_i (arb_req),
    .ptr_i (last_grant_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  always_comb begin
    win_gnt = arb_gnt;
    win_idx = arb_idx;
    if (Port0Prio && bus.req_valid_i[0]) begin
      win_gnt = num_ports'(1);
      win_idx = '0;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    idx_d        = idx_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rsp_data_d   = rsp_data_q;

    bus.req_ready_o   = '0;
    bus.rsp_valid_o   = '0;
    bus.rsp_write_o   = 1'b0;
    bus.rsp_data_o    = rsp_data_q;
    bus.mem_addr_o    = addr_q;
    bus.mem_write_o   = wdata_q;
    bus.mem_r_valid_o = 1'b0;
    bus.mem_w_valid_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.mem_data_ready_i && |bus.req_valid_i) begin
          bus.req_ready_o = win_gnt;
          idx_d           = win_idx;
          write_d         = bus.req_write_i[win_idx];
          addr_d          = bus.req_addr_i[win_idx];
          wdata_d         = bus.req_wdata_i[win_idx];
          if (!Port0Prio || win_idx != '0) begin
            last_grant_d = win_idx;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        bus.mem_r_valid_o = !write_q;
        bus.mem_w_valid_o = write_q;
        state_d           = write_q ? WAIT_WR : WAIT_RD;
      end
      WAIT_RD: begin
        if (bus.mem_r_valid_i) begin
          bus.rsp_valid_o[idx_q] = 1'b1;
          bus.rsp_data_o         = bus.mem_read_i;
          rsp_data_d             = bus.mem_read_i;
          state_d                = IDLE;
        end
      end
      WAIT_WR: begin
        if (bus.mem_data_ready_i) begin
          bus.rsp_valid_o[idx_q] = 1'b1;
          bus.rsp_write_o        = 1'b1;
          state_d                = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      last_grant_q <= LastPort;
      idx_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      idx_q        <= idx_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (4 ports, 32-bit address, 64-bit line).
module tb_mem_arbiter;

  localparam int unsigned NP = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if #(.num_ports(NP), .addr_width(32), .line_width(64)) bus ();

  mem_arbiter #(.num_ports(NP), .addr_width(32), .line_width(64)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic run_read(input int unsigned port, input logic [31:0] addr,
                          input logic [63:0] data, input int unsigned lat);
    int unsigned n;
    logic [63:0] oh;
    oh       = '0;
    oh[port] = 1'b1;
    n        = 0;
    settle();
    while (bus.req_ready_o == '0 && n < 20) begin
      tick();
      settle();
      n++;
    end
    check("grant", 64'(bus.req_ready_o), oh);
    tick();
    settle();
    check("issue_rvalid", 64'(bus.mem_r_valid_o), 64'd1);
    check("issue_wvalid", 64'(bus.mem_w_valid_o), 64'd0);
    check("issue_addr", 64'(bus.mem_addr_o), 64'(addr));
    check("issue_no_grant", 64'(bus.req_ready_o), 64'd0);
    for (int unsigned k = 0; k < lat; k++) begin
      tick();
      settle();
      check("rd_wait_quiet", 64'({bus.rsp_valid_o, bus.req_ready_o, bus.mem_r_valid_o}), 64'd0);
    end
    tick();
    bus.mem_r_valid_i = 1'b1;
    bus.mem_read_i    = data;
    settle();
    check("rsp_valid", 64'(bus.rsp_valid_o), oh);
    check("rsp_write", 64'(bus.rsp_write_o), 64'd0);
    check("rsp_data", bus.rsp_data_o, data);
    check("rsp_no_grant", 64'(bus.req_ready_o), 64'd0);
    tick();
    bus.mem_r_valid_i = 1'b0;
    bus.mem_read_i    = '0;
  endtask

  initial begin
    int unsigned order [5];
    int unsigned bad;

    bus.req_valid_i      = '0;
    bus.req_write_i      = '0;
    bus.req_addr_i       = '0;
    bus.req_wdata_i      = '0;
    bus.mem_data_ready_i = 1'b1;
    bus.mem_r_valid_i    = 1'b0;
    bus.mem_read_i       = '0;

    // Reset values
    tick();
    tick();
    settle();
    check("rst_ready", 64'(bus.req_ready_o), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("rst_rsp_write", 64'(bus.rsp_write_o), 64'd0);
    check("rst_rsp_data", bus.rsp_data_o, 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr_o), 64'd0);
    check("rst_mem_valids", 64'({bus.mem_r_valid_o, bus.mem_w_valid_o}), 64'd0);
    check("rst_mem_write", bus.mem_write_o, 64'd0);
    tick();
    rst_n = 1'b1;

    // Single read on port 2, response 5 cycles after issue
    bus.req_addr_i[2]  = 32'h40;
    bus.req_valid_i[2] = 1'b1;
    run_read(2, 32'h40, 64'hDEAD_BEEF_CAFE_F00D, 4);
    bus.req_valid_i = '0;
    settle();
    check("single_pulse", 64'({bus.req_ready_o, bus.rsp_valid_o}), 64'd0);
    tick();

    // All four ports reading continuously from reset
    for (int unsigned p = 0; p < NP; p++) bus.req_addr_i[p] = 32'h1000 + p * 32'h100;
    bus.req_valid_i = '1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    order = '{0, 1, 2, 3, 0};
    for (int unsigned k = 0; k < 5; k++)
      run_read(order[k], 32'h1000 + order[k] * 32'h100, 64'hA5A5_0000_0000_0000 | 64'(k), 0);
    bus.req_valid_i = '0;

    // Write on port 1 with 12 cycles of mem_data_ready low (write-back eject)
    bus.req_write_i[1] = 1'b1;
    bus.req_addr_i[1]  = 32'h80;
    bus.req_wdata_i[1] = 64'h1122_3344_5566_7788;
    bus.req_valid_i[1] = 1'b1;
    settle();
    check("wr_grant", 64'(bus.req_ready_o), 64'b0010);
    tick();
    bus.req_valid_i      = '0;
    bus.mem_data_ready_i = 1'b0;
    settle();
    check("wr_wvalid", 64'(bus.mem_w_valid_o), 64'd1);
    check("wr_rvalid", 64'(bus.mem_r_valid_o), 64'd0);
    check("wr_data", bus.mem_write_o, 64'h1122_3344_5566_7788);
    check("wr_addr", 64'(bus.mem_addr_o), 64'h80);
    bad = 0;
    for (int unsigned k = 0; k < 12; k++) begin
      tick();
      settle();
      if (bus.rsp_valid_o != '0 || bus.mem_w_valid_o || bus.req_ready_o != '0) bad++;
    end
    check("wr_eject_quiet", 64'(bad), 64'd0);
    tick();
    bus.mem_data_ready_i = 1'b1;
    settle();
    check("wr_ack_valid", 64'(bus.rsp_valid_o), 64'b0010);
    check("wr_ack_write", 64'(bus.rsp_write_o), 64'd1);
    tick();
    settle();
    check("wr_ack_once", 64'(bus.rsp_valid_o), 64'd0);
    bus.req_write_i = '0;
    tick();

    // Port 3 waits while mem_data_ready is low, granted the cycle it rises
    bus.mem_data_ready_i = 1'b0;
    bus.req_addr_i[3]    = 32'h300;
    bus.req_valid_i[3]   = 1'b1;
    bad = 0;
    for (int unsigned k = 0; k < 3; k++) begin
      settle();
      if (bus.req_ready_o != '0) bad++;
      tick();
    end
    check("busy_no_grant", 64'(bad), 64'd0);
    bus.mem_data_ready_i = 1'b1;
    run_read(3, 32'h300, 64'h0123_4567_89AB_CDEF, 0);
    bus.req_valid_i = '0;

    // Reset in WAIT_RD: stale response dropped, port 0 wins next
    bus.req_addr_i[2]  = 32'h40;
    bus.req_valid_i[2] = 1'b1;
    settle();
    check("rstmid_grant", 64'(bus.req_ready_o), 64'b0100);
    tick();
    bus.req_valid_i = '0;
    tick();
    rst_n = 1'b0;
    settle();
    check("rstmid_outputs", 64'({bus.rsp_valid_o, bus.req_ready_o, bus.mem_r_valid_o}), 64'd0);
    check("rstmid_addr", 64'(bus.mem_addr_o), 64'd0);
    tick();
    rst_n             = 1'b1;
    bus.mem_r_valid_i = 1'b1;
    bus.mem_read_i    = 64'hFFFF_0000_FFFF_0000;
    settle();
    check("rstmid_drop_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("rstmid_drop_data", bus.rsp_data_o, 64'd0);
    tick();
    bus.mem_r_valid_i = 1'b0;
    bus.mem_read_i    = '0;
    bus.req_valid_i   = '1;
    run_read(0, 32'h1000, 64'h5555_AAAA_5555_AAAA, 0);
    bus.req_valid_i = '0;

`ifdef MEM_ARB_PORT0_PRIO_EN
    // Port 0 priority: always wins while valid, port 1 only once port 0 drops
    bus.req_valid_i = 4'b0011;
    for (int unsigned k = 0; k < 3; k++) run_read(0, 32'h1000, 64'h00C0_0000_0000_0000 | 64'(k), 0);
    bus.req_valid_i = 4'b0010;
    run_read(1, 32'h1100, 64'h00C1_0000_0000_0000, 0);
    bus.req_valid_i = '0;
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
